// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one execute-stage ALU between the EX stage (port 0)
// and the address/branch-target unit (port 1). Grants one requester at a time,
// latches its operands, registers the ALU result/flags and returns them over a
// valid/ready response tagged with the requester id.
// Optional build macro: ALU_SHARE_FIXED_PRIO_EN (requester 0 always wins
// contention; otherwise round-robin arbitration).
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FLAG_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][DATA_WIDTH-1:0] req_a,
  input  logic [1:0][DATA_WIDTH-1:0] req_b,
  input  logic [1:0][2:0]            req_op,
  output logic [DATA_WIDTH-1:0]      alu_a,
  output logic [DATA_WIDTH-1:0]      alu_b,
  output logic [2:0]                 alu_cntrl,
  input  logic [DATA_WIDTH-1:0]      alu_result,
  input  logic [FLAG_WIDTH-1:0]      alu_flags,
  output logic                       rsp_valid,
  output logic                       rsp_id,
  output logic [DATA_WIDTH-1:0]      rsp_result,
  output logic [FLAG_WIDTH-1:0]      rsp_flags,
  output logic                       rsp_err,
  input  logic                       rsp_ready
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
  logic [OP_W-1:0]         op_op_q, op_op_d;
  logic                    op_id_q, op_id_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic [FLAG_WIDTH-1:0]   rsp_flags_q, rsp_flags_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    grant_id;
  logic                    illegal_op;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic                    last_grant_q, last_grant_d;
`endif

  // Winner selection: fixed priority to port 0, or round-robin on last_grant
  always_comb begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
    grant_id = ~req_valid[0];
`else
    grant_id = req_valid[1] & (~req_valid[0] | ~last_grant_q);
`endif
  end

  // Codes 001 and 111 have no ALU function behind them
  assign illegal_op = (op_op_q == 3'b001) || (op_op_q == 3'b111);

  // Next-state, grant and response capture logic
  always_comb begin
    state_d      = state_q;
    req_ready    = 2'b00;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_op_d      = op_op_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant_id] = 1'b1;
          op_a_d              = req_a[grant_id];
          op_b_d              = req_b[grant_id];
          op_op_d             = req_op[grant_id];
          op_id_d             = grant_id;
`ifndef ALU_SHARE_FIXED_PRIO_EN
          last_grant_d        = grant_id;
`endif
          state_d             = EXEC;
        end
      end
      EXEC: begin
        // Illegal selects read as zero, matching the result mux
        rsp_result_d = illegal_op ? '0 : alu_result;
        rsp_flags_d  = illegal_op ? '0 : alu_flags;
        rsp_err_d    = illegal_op;
        rsp_id_d     = op_id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, operand and response registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_op_q      <= 3'b000;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_op_q      <= op_op_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifndef ALU_SHARE_FIXED_PRIO_EN
  // Round-robin pointer; resets to 1 so port 0 wins the first contention
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_cntrl  = op_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; the bench also plays the ALU.
module tb_alu_share_arbiter;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][63:0]  req_a;
  logic [1:0][63:0]  req_b;
  logic [1:0][2:0]   req_op;
  logic [63:0]       alu_a;
  logic [63:0]       alu_b;
  logic [2:0]        alu_cntrl;
  logic [63:0]       alu_result;
  logic [3:0]        alu_flags;
  logic              rsp_valid;
  logic              rsp_id;
  logic [63:0]       rsp_result;
  logic [3:0]        rsp_flags;
  logic              rsp_err;
  logic              rsp_ready;

  int passed = 0;
  int total  = 0;

  alu_share_arbiter #(.DATA_WIDTH(64), .FLAG_WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cntrl  (alu_cntrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: flags = {negative, zero, overflow, carry}; illegal codes give junk
  logic [64:0] sum;
  logic        fc;
  logic        fv;
  always_comb begin
    sum        = '0;
    fc         = 1'b0;
    fv         = 1'b0;
    alu_result = '0;
    alu_flags  = '0;
    case (alu_cntrl)
      3'b000: alu_result = alu_b;
      3'b010: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[63:0];
        fc         = sum[64];
        fv         = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      3'b011: begin
        sum        = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
        alu_result = sum[63:0];
        fc         = sum[64];
        fv         = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
      end
      3'b100: alu_result = alu_a & alu_b;
      3'b101: alu_result = alu_a | alu_b;
      3'b110: alu_result = alu_a ^ alu_b;
      default: alu_result = 64'h0000_0000_DEAD_BEEF;
    endcase
    if (alu_cntrl == 3'b001 || alu_cntrl == 3'b111) begin
      alu_flags = 4'hF;
    end else begin
      alu_flags = {alu_result[63], alu_result == 64'd0, fv, fc};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One operation from IDLE; caller is just after a falling edge in IDLE
  task automatic run_op(input string tag, input logic [1:0] vmask, input logic exp_id,
                        input logic [63:0] exp_res, input logic [3:0] exp_flg,
                        input logic exp_err, input logic hold, input int stall);
    logic [1:0] exp_rdy;
    exp_rdy   = exp_id ? 2'b10 : 2'b01;
    req_valid = vmask;
    rsp_ready = 1'b0;
    #1;
    chk({tag, ".grant"}, 64'(req_ready), 64'(exp_rdy));
    @(negedge clk);
    if (!hold) req_valid = 2'b00;
    #1;
    chk({tag, ".exec_rdy"}, 64'(req_ready), 64'(2'b00));
    chk({tag, ".exec_vld"}, 64'(rsp_valid), 64'(1'b0));
    @(negedge clk);
    chk({tag, ".rsp_vld"}, 64'(rsp_valid), 64'(1'b1));
    chk({tag, ".rsp_id"},  64'(rsp_id), 64'(exp_id));
    chk({tag, ".result"},  rsp_result, exp_res);
    chk({tag, ".flags"},   64'(rsp_flags), 64'(exp_flg));
    chk({tag, ".err"},     64'(rsp_err), 64'(exp_err));
    for (int i = 0; i < stall; i++) begin
      req_valid = 2'b11;
      @(negedge clk);
      chk({tag, ".stall_vld"}, 64'(rsp_valid), 64'(1'b1));
      chk({tag, ".stall_res"}, rsp_result, exp_res);
      chk({tag, ".stall_flg"}, 64'(rsp_flags), 64'(exp_flg));
      chk({tag, ".stall_rdy"}, 64'(req_ready), 64'(2'b00));
    end
    req_valid = hold ? vmask : 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".rsp_done"}, 64'(rsp_valid), 64'(1'b0));
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst.rsp_valid", 64'(rsp_valid), 64'(1'b0));
    chk("rst.req_ready", 64'(req_ready), 64'(2'b00));
    chk("rst.alu_cntrl", 64'(alu_cntrl), 64'(3'b000));
    chk("rst.alu_a",     alu_a, 64'd0);
    chk("rst.rsp_id",    64'(rsp_id), 64'(1'b0));

    // Requester 1 alone: 5 + 3
    req_a[1] = 64'd5; req_b[1] = 64'd3; req_op[1] = 3'b010;
    run_op("add1", 2'b10, 1'b1, 64'd8, 4'b0000, 1'b0, 1'b0, 0);

    // Contention: AND on port 0, XOR on port 1
    req_a[0] = 64'hF0; req_b[0] = 64'h3C; req_op[0] = 3'b100;
    req_a[1] = 64'hF0; req_b[1] = 64'h3C; req_op[1] = 3'b110;
    for (int i = 0; i < 4; i++) begin
      logic eid;
`ifdef ALU_SHARE_FIXED_PRIO_EN
      eid = 1'b0;
`else
      eid = (i % 2) != 0;
`endif
      run_op("contend", 2'b11, eid, eid ? 64'hCC : 64'h30, 4'b0000, 1'b0, 1'b1, 0);
    end
    req_valid = 2'b00;

    // Backpressure: 2 - 3 held for 5 cycles
    req_a[0] = 64'd2; req_b[0] = 64'd3; req_op[0] = 3'b011;
    run_op("sub_bp", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0, 1'b0, 5);

    // Illegal op then pass-B
    req_a[0] = 64'd7; req_b[0] = 64'd7; req_op[0] = 3'b111;
    run_op("illegal", 2'b01, 1'b0, 64'd0, 4'b0000, 1'b1, 1'b0, 0);
    req_a[0] = 64'd0; req_b[0] = 64'd9; req_op[0] = 3'b000;
    run_op("passb", 2'b01, 1'b0, 64'd9, 4'b0000, 1'b0, 1'b0, 0);

    // Mid-operation reset during EXEC
    req_a[0] = 64'hF0; req_b[0] = 64'h3C; req_op[0] = 3'b101;
    req_valid = 2'b01;
    #1;
    chk("mid.grant", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b00;
    chk("mid.exec_cntrl", 64'(alu_cntrl), 64'(3'b101));
    reset = 1'b0;
    @(negedge clk);
    chk("mid.no_rsp", 64'(rsp_valid), 64'(1'b0));
    chk("mid.cntrl_rst", 64'(alu_cntrl), 64'(3'b000));
    reset = 1'b1;
    run_op("mid.after", 2'b11, 1'b0, 64'hFC, 4'b0000, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
